// File: rtl/mem_port_arbiter.sv
// Two-requester arbiter for the shared instruction/data memory port of the multicycle core.
// Port 0 is the CPU datapath, port 1 the program loader; each access holds memory for MEM_LAT cycles.
module mem_port_arbiter #(
  parameter int WIDTH   = 32,
  parameter int ADDR_W  = 32,
  parameter int MEM_LAT = 2
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              cpu_req,
  input  logic              cpu_we,
  input  logic [ADDR_W-1:0] cpu_addr,
  input  logic [WIDTH-1:0]  cpu_wdata,
  output logic              cpu_ack,
  output logic [WIDTH-1:0]  cpu_rdata,
  output logic              cpu_stall,
  input  logic              ldr_req,
  input  logic              ldr_we,
  input  logic [ADDR_W-1:0] ldr_addr,
  input  logic [WIDTH-1:0]  ldr_wdata,
  input  logic              ldr_lock,
  output logic              ldr_ack,
  output logic [WIDTH-1:0]  ldr_rdata,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [WIDTH-1:0]  mem_wdata,
  output logic              mem_we,
  output logic              mem_re,
  input  logic [WIDTH-1:0]  mem_rdata,
  output logic              busy,
  output logic [1:0]        fsm_state
);

  // Handshake: a requester holds req/we/addr/wdata until its ack, which pulses for one
  // cycle in RESP; a request dropped after grant still completes and still acks.

  localparam logic [1:0] IDLE   = 2'd0;
  localparam logic [1:0] ACCESS = 2'd1;
  localparam logic [1:0] RESP   = 2'd2;
  localparam logic [3:0] LAT_M1 = 4'(MEM_LAT - 1);

  logic [1:0] state;
  logic       owner;
  logic       last_gnt;
  logic       we_r;
  logic [3:0] count;
  logic       cpu_elig;
  logic       grant;
  logic       gnt_sel;

  assign cpu_elig = cpu_req & ~ldr_lock;
  assign grant    = cpu_elig | ldr_req;

  // On a tie the side that did not win last time gets the port.
  always_comb begin
    gnt_sel = ldr_req;
    if (cpu_elig && ldr_req) gnt_sel = ~last_gnt;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state     <= IDLE;
      owner     <= 1'b0;
      last_gnt  <= 1'b1;
      we_r      <= 1'b0;
      count     <= 4'd0;
      mem_addr  <= '0;
      mem_wdata <= '0;
      cpu_rdata <= '0;
      ldr_rdata <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (grant) begin
            owner     <= gnt_sel;
            last_gnt  <= gnt_sel;
            we_r      <= gnt_sel ? ldr_we : cpu_we;
            mem_addr  <= gnt_sel ? ldr_addr : cpu_addr;
            mem_wdata <= gnt_sel ? ldr_wdata : cpu_wdata;
            count     <= LAT_M1;
            state     <= ACCESS;
          end
        end
        ACCESS: begin
          if (count == 4'd0) begin
            if (!we_r) begin
              if (owner) ldr_rdata <= mem_rdata;
              else       cpu_rdata <= mem_rdata;
            end
            state <= RESP;
          end else begin
            count <= count - 4'd1;
          end
        end
        RESP:    state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

  // count still holds its load value only in the first ACCESS cycle.
  assign mem_we    = (state == ACCESS) & we_r & (count == LAT_M1);
  assign mem_re    = (state == ACCESS) & ~we_r;
  assign cpu_ack   = (state == RESP) & ~owner;
  assign ldr_ack   = (state == RESP) & owner;
  assign cpu_stall = cpu_req & ~cpu_ack;
  assign busy      = (state != IDLE);
  assign fsm_state = state;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Directed bench for mem_port_arbiter: table of single transactions plus hand-written
// sequences for arbitration, loader lock, dropped request, reset abort and MEM_LAT=1.
module tb_mem_port_arbiter;

  localparam int LAT = 2;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        cpu_req = 0, cpu_we = 0, ldr_req = 0, ldr_we = 0, ldr_lock = 0;
  logic [31:0] cpu_addr = 0, cpu_wdata = 0, ldr_addr = 0, ldr_wdata = 0, mem_data = 0;
  logic        cpu_ack, cpu_stall, ldr_ack, mem_we, mem_re, busy;
  logic [31:0] cpu_rdata, ldr_rdata, mem_addr, mem_wdata;
  logic [1:0]  fsm_state;

  logic        s1_cpu_req = 0, s1_cpu_we = 0, s1_ldr_req = 0, s1_ldr_we = 0, s1_ldr_lock = 0;
  logic [31:0] s1_cpu_addr = 0, s1_cpu_wdata = 0, s1_ldr_addr = 0, s1_ldr_wdata = 0, s1_mem_rdata = 0;
  logic        s1_cpu_ack, s1_cpu_stall, s1_ldr_ack, s1_mem_we, s1_mem_re, s1_busy;
  logic [31:0] s1_cpu_rdata, s1_ldr_rdata, s1_mem_addr, s1_mem_wdata;
  logic [1:0]  s1_fsm_state;

  int checks = 0;
  int failures = 0;
  logic [31:0] exp_q[$];

  always #5 clk = ~clk;

  mem_port_arbiter #(.WIDTH(32), .ADDR_W(32), .MEM_LAT(LAT)) u_dut (
    .clk(clk), .rst(rst),
    .cpu_req(cpu_req), .cpu_we(cpu_we), .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata),
    .cpu_ack(cpu_ack), .cpu_rdata(cpu_rdata), .cpu_stall(cpu_stall),
    .ldr_req(ldr_req), .ldr_we(ldr_we), .ldr_addr(ldr_addr), .ldr_wdata(ldr_wdata),
    .ldr_lock(ldr_lock), .ldr_ack(ldr_ack), .ldr_rdata(ldr_rdata),
    .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_we(mem_we), .mem_re(mem_re),
    .mem_rdata(mem_data), .busy(busy), .fsm_state(fsm_state)
  );

  mem_port_arbiter #(.WIDTH(32), .ADDR_W(32), .MEM_LAT(1)) u_dut1 (
    .clk(clk), .rst(rst),
    .cpu_req(s1_cpu_req), .cpu_we(s1_cpu_we), .cpu_addr(s1_cpu_addr), .cpu_wdata(s1_cpu_wdata),
    .cpu_ack(s1_cpu_ack), .cpu_rdata(s1_cpu_rdata), .cpu_stall(s1_cpu_stall),
    .ldr_req(s1_ldr_req), .ldr_we(s1_ldr_we), .ldr_addr(s1_ldr_addr), .ldr_wdata(s1_ldr_wdata),
    .ldr_lock(s1_ldr_lock), .ldr_ack(s1_ldr_ack), .ldr_rdata(s1_ldr_rdata),
    .mem_addr(s1_mem_addr), .mem_wdata(s1_mem_wdata), .mem_we(s1_mem_we), .mem_re(s1_mem_re),
    .mem_rdata(s1_mem_rdata), .busy(s1_busy), .fsm_state(s1_fsm_state)
  );

  typedef struct {
    logic        port;
    logic        we;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [31:0] mdata;
    logic [31:0] exp_rdata;
  } vec_t;

  vec_t vecs[6];

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic drop_all();
    @(posedge clk); #1;
    cpu_req = 0;
    ldr_req = 0;
  endtask

  task automatic do_txn(input vec_t v, input int idx);
    string tag;
    tag = $sformatf("vec%0d", idx);
    @(posedge clk); #1;
    mem_data = v.mdata;
    if (v.port) begin
      ldr_req = 1; ldr_we = v.we; ldr_addr = v.addr; ldr_wdata = v.wdata;
    end else begin
      cpu_req = 1; cpu_we = v.we; cpu_addr = v.addr; cpu_wdata = v.wdata;
    end
    @(negedge clk);
    chk({tag, "_idle_busy"}, busy, 0);
    for (int k = 1; k <= LAT; k++) begin
      @(negedge clk);
      chk({tag, "_acc_busy"}, busy, 1);
      chk({tag, "_acc_re"}, mem_re, !v.we);
      chk({tag, "_acc_we"}, mem_we, v.we && k == 1);
      chk({tag, "_acc_addr"}, mem_addr, v.addr);
      chk({tag, "_acc_ack"}, {cpu_ack, ldr_ack}, 0);
      if (v.we) chk({tag, "_acc_wdata"}, mem_wdata, v.wdata);
      if (!v.port) chk({tag, "_acc_stall"}, cpu_stall, 1);
    end
    @(negedge clk);
    chk({tag, "_ack"}, {cpu_ack, ldr_ack}, v.port ? 2'b01 : 2'b10);
    chk({tag, "_resp_strobes"}, {mem_we, mem_re}, 0);
    chk({tag, "_rdata"}, v.port ? ldr_rdata : cpu_rdata, v.exp_rdata);
    if (!v.port) chk({tag, "_resp_stall"}, cpu_stall, 0);
    drop_all();
  endtask

  initial begin
    #200000;
    $display("FAIL global_timeout: got running expected finished");
    $fatal(1, "timeout");
  end

  initial begin
    int last, we_cnt, acks, bad, found;
    logic who;

    vecs[0] = '{0, 0, 32'h40,  32'h0,        32'h2010000A, 32'h2010000A};
    vecs[1] = '{1, 0, 32'h100, 32'h0,        32'h12345678, 32'h12345678};
    vecs[2] = '{0, 1, 32'h80,  32'hDEADBEEF, 32'hFFFFFFFF, 32'h2010000A};
    vecs[3] = '{1, 1, 32'h0,   32'h00000011, 32'hFFFFFFFF, 32'h12345678};
    vecs[4] = '{0, 0, 32'h44,  32'h0,        32'hCAFEF00D, 32'hCAFEF00D};
    vecs[5] = '{1, 0, 32'h104, 32'h0,        32'h00000000, 32'h00000000};

    // reset state
    #2;
    chk("rst_busy", busy, 0);
    chk("rst_strobes", {mem_we, mem_re, cpu_ack, ldr_ack}, 0);
    chk("rst_mem_addr", mem_addr, 0);
    chk("rst_mem_wdata", mem_wdata, 0);
    chk("rst_rdata", {cpu_rdata, ldr_rdata}, 0);
    @(negedge clk);
    @(negedge clk);
    rst = 1;

    for (int i = 0; i < 6; i++) do_txn(vecs[i], i);

    // both requesters held: last_gnt=1 after vec5, so CPU, LDR, CPU, spaced LAT+2 apart
    @(posedge clk); #1;
    mem_data = 32'hA1B2C3D4;
    cpu_req = 1; cpu_we = 0; cpu_addr = 32'h200;
    ldr_req = 1; ldr_we = 0; ldr_addr = 32'h300;
    exp_q.push_back(0); exp_q.push_back(1); exp_q.push_back(0);
    last = -1;
    for (int i = 0; i < 16; i++) begin
      @(negedge clk);
      if (cpu_ack || ldr_ack) begin
        who = ldr_ack;
        chk("arb_excl", cpu_ack & ldr_ack, 0);
        if (exp_q.size() > 0) chk("arb_order", who, exp_q.pop_front());
        if (last >= 0) chk("arb_gap", i - last, LAT + 2);
        last = i;
      end
    end
    chk("arb_all_acks", exp_q.size(), 0);
    chk("arb_rdata", {cpu_rdata, ldr_rdata}, {32'hA1B2C3D4, 32'hA1B2C3D4});
    drop_all();
    found = 0;
    for (int i = 0; i < 10 && !found; i++) begin
      @(negedge clk);
      if (!busy) found = 1;
    end
    chk("arb_idle", found, 1);

    // loader lock: CPU held off while loader writes four words
    @(posedge clk); #1;
    ldr_lock = 1;
    cpu_req = 1; cpu_we = 0; cpu_addr = 32'h400;
    we_cnt = 0; acks = 0; bad = 0;
    for (int j = 0; j < 4; j++) exp_q.push_back(32'(j * 4));
    for (int j = 0; j < 4; j++) begin
      ldr_req = 1; ldr_we = 1; ldr_addr = 32'(j * 4); ldr_wdata = 32'(j);
      found = 0;
      for (int i = 0; i < 10 && !found; i++) begin
        @(negedge clk);
        if (mem_we) begin
          we_cnt++;
          chk("lock_we_addr", mem_addr, exp_q.pop_front());
        end
        if (cpu_ack || !cpu_stall) bad++;
        if (ldr_ack) begin
          acks++;
          found = 1;
        end
      end
      @(posedge clk); #1;
      ldr_req = 0;
    end
    chk("lock_ldr_acks", acks, 4);
    chk("lock_we_cycles", we_cnt, 4);
    chk("lock_cpu_held", bad, 0);
    mem_data = 32'h5555AAAA;
    ldr_lock = 0;
    found = 0;
    for (int i = 0; i < 10 && !found; i++) begin
      @(negedge clk);
      if (cpu_ack) found = 1;
    end
    chk("unlock_cpu_ack", found, 1);
    chk("unlock_cpu_rdata", cpu_rdata, 32'h5555AAAA);
    drop_all();

    // CPU write with request dropped during ACCESS
    @(posedge clk); #1;
    cpu_req = 1; cpu_we = 1; cpu_addr = 32'h80; cpu_wdata = 32'hDEADBEEF;
    @(negedge clk);
    @(negedge clk);
    chk("drop_we_first", mem_we, 1);
    @(posedge clk); #1;
    cpu_req = 0;
    @(negedge clk);
    chk("drop_we_second", mem_we, 0);
    chk("drop_wdata", mem_wdata, 32'hDEADBEEF);
    @(negedge clk);
    chk("drop_ack", cpu_ack, 1);
    chk("drop_rdata", cpu_rdata, 32'h5555AAAA);

    // asynchronous reset in the middle of a loader read
    @(posedge clk); #1;
    mem_data = 32'h600DCAFE;
    ldr_req = 1; ldr_we = 0; ldr_addr = 32'h500;
    @(negedge clk);
    @(negedge clk);
    chk("rstmid_pre_busy", busy, 1);
    #1 rst = 0;
    #1;
    chk("rstmid_busy", busy, 0);
    chk("rstmid_re", mem_re, 0);
    chk("rstmid_state", fsm_state, 0);
    chk("rstmid_mem_addr", mem_addr, 0);
    chk("rstmid_rdata", {cpu_rdata, ldr_rdata}, 0);
    @(negedge clk);
    rst = 1;
    found = 0;
    for (int i = 0; i < 10 && !found; i++) begin
      @(negedge clk);
      if (ldr_ack) found = 1;
    end
    chk("rstmid_ldr_ack", found, 1);
    chk("rstmid_ldr_rdata", ldr_rdata, 32'h600DCAFE);
    drop_all();

    // MEM_LAT=1 instance: single ACCESS cycle, ack two cycles after the request
    @(posedge clk); #1;
    s1_mem_rdata = 32'h00001111;
    s1_cpu_req = 1; s1_cpu_addr = 32'h10;
    @(negedge clk);
    chk("lat1_idle", s1_busy, 0);
    @(negedge clk);
    chk("lat1_access", {s1_busy, s1_mem_re, s1_cpu_ack}, 3'b110);
    @(negedge clk);
    chk("lat1_ack", {s1_busy, s1_mem_re, s1_cpu_ack}, 3'b101);
    chk("lat1_rdata", s1_cpu_rdata, 32'h00001111);
    @(posedge clk); #1;
    s1_cpu_req = 0;
    @(negedge clk);
    chk("lat1_back_idle", s1_busy, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
